mem_req_batcher: RTL and testbench
==================================

Name: mem_req_batcher

Overview:
- Collects incoming memory requests into a 16-slot batch and attaches an 8-bit sort key to each one.
- Presents the full batch as sixteen 76-bit entries to the downstream 16-element sorter: key in [75:68], payload in [67:0].
- Launches a batch when it is full, when a timeout expires, or on an explicit flush.
- Empty slots are padded with key 8'hFF so they sort last; the downstream consumer uses batch_count to discard them.

Parameters:
- KEY_LSB, 20: bit position in req_data of the 7-bit row/bank field used as the sort key.
- TIMEOUT, 64: number of cycles after the first accept in a batch before a partial batch is forced out; 0 disables the timeout.
- TMR_W, 8: width of the timeout counter; must satisfy TIMEOUT < 2**TMR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present on req_data.
- req_ready  out  1  batcher can accept a request.
- req_data  in  68  request payload.
- flush  in  1  single-cycle pulse: launch the current partial batch.
- batch_valid  out  1  batch_data and batch_count are stable and valid.
- batch_ready  in  1  downstream consumes the batch.
- batch_count  out  5  number of valid slots, 0..16.
- batch_data  out  1216  slot i occupies bits [76*i+75 : 76*i].

Behaviour:
- Single clock domain: clk, with rst_n asynchronous and active-low.
- Reset values:
  - state = FILL, count = 0, timer = 0.
  - Every slot = {8'hFF, 68'h0}.
  - batch_valid = 0, req_ready = 1 after reset releases, batch_count = 0.
- States: FILL and HOLD.
  - req_ready = (state == FILL).
  - batch_valid = (state == HOLD).
  - Both are decoded from registered state only; there is no combinational path from any input to these outputs.
- In FILL, accepting a request (req_valid & req_ready):
  - slot[count] <= {1'b0, req_data[KEY_LSB+6:KEY_LSB], req_data}.
  - count <= count + 1.
  - Bit 75 of a valid key is always 0, so every valid key is below 8'h80 and always sorts ahead of a pad slot.
  - Requests with equal keys keep arrival order, because the sorter breaks ties on slot index.
- Timer:
  - Holds 0 while count == 0.
  - Increments every FILL cycle while count > 0, saturating at TIMEOUT.
- Launch condition, evaluated in FILL on post-accept values:
  - count_next == 16, or
  - TIMEOUT != 0 and timer_next == TIMEOUT and count_next > 0, or
  - flush and count_next > 0.
  - On launch: state <= HOLD. batch_valid rises on the following edge, one cycle latency.
- A request accepted in the same cycle as a timeout or flush is included in the launched batch.
- flush while count_next == 0 is ignored; an empty batch is never launched.
- In HOLD:
  - req_ready = 0; batch_data and batch_count are held constant.
  - flush is ignored; the timer is frozen.
- On batch_valid & batch_ready:
  - All slots return to pad value; count and timer return to 0; state <= FILL.
  - req_ready returns the next cycle.
  - There is no same-cycle refill.
- batch_ready while in FILL is ignored.
- batch_count = count (registered).
- Full-batch throughput: 16 accepts + 1 HOLD cycle minimum, i.e. 17 cycles per batch.
- Reset asserted in the middle of a fill or hold:
  - All state clears immediately, without waiting for a clock edge.
  - Any partial batch is discarded.
  - batch_valid drops asynchronously.

Decomposition:
- Shared package mem_ctrl_pkg holds:
  - NUM_SLOTS = 16, PAYLOAD_W = 68, KEY_W = 8, ENTRY_W = 76.
  - PAD_KEY = 8'hFF.
  - The state enum {FILL, HOLD}.
- One natural sub-module: batch_timer, which implements the saturating timeout counter with clear and enable.
- Slot storage and the FSM stay in the top module.

Test Plan:
- Reset, then 16 back-to-back requests with req_data[26:20] = 15 down to 0:
  - batch_valid rises exactly 1 cycle after the 16th accept, with batch_count = 16.
  - Slot i key = 15 - i.
  - req_ready = 0 throughout HOLD.
- 3 requests, then idle with TIMEOUT = 64:
  - batch_valid rises 64 cycles after the first accept (+1 cycle latency), with batch_count = 3.
  - Slots 3..15 = {8'hFF, 68'h0}.
- flush pulsed in the same cycle as the 5th accept → batch_count = 5, and slot 4 holds the 5th payload.
- flush with count = 0 → no launch; batch_valid stays 0 for 100 cycles.
- Hold batch_ready = 0 for 20 cycles in HOLD:
  - batch_data stays bit-stable and no request is accepted.
  - Then batch_ready = 1 → req_ready = 1 the next cycle, with batch_count = 0.
- Assert rst_n = 0 asynchronously (between edges) while count = 7 → batch_count = 0 and req_ready = 1 after release, with no batch emitted.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and sizes for the memory request batcher.
//   NUM_SLOTS / PAYLOAD_W / KEY_W / ENTRY_W : batch geometry
//   CNT_W / SLOT_IDX_W                      : occupancy counter and slot index widths
//   PAD_KEY / PAD_ENTRY                     : filler for empty slots (sorts last)
//   state_e                                 : batcher FSM states
package mem_ctrl_pkg;

   localparam int unsigned NUM_SLOTS  = 16;
   localparam int unsigned PAYLOAD_W  = 68;
   localparam int unsigned KEY_W      = 8;
   localparam int unsigned ENTRY_W    = KEY_W + PAYLOAD_W;
   localparam int unsigned CNT_W      = $clog2(NUM_SLOTS + 1);
   localparam int unsigned SLOT_IDX_W = $clog2(NUM_SLOTS);

   localparam logic [KEY_W-1:0]   PAD_KEY   = 8'hFF;
   localparam logic [ENTRY_W-1:0] PAD_ENTRY = {PAD_KEY, {PAYLOAD_W{1'b0}}};

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_e;

endpackage

// File: rtl/batch_timer.sv
// Saturating timeout counter for a partially filled batch.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : return the count to zero (takes priority over en_i)
//   en_i       : count up by one, saturating at TIMEOUT
//   timer_d_c  : next-state count (combinational), used for same-cycle launch decisions
module batch_timer #(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned TMR_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [TMR_W-1:0] timer_d_c
);

   logic [TMR_W-1:0] timer_q, timer_d;

   // Next count: clear, saturating increment, or hold.
   always_comb begin
      timer_d = timer_q;
      if (clr_i) begin
         timer_d = '0;
      end else if (en_i && (timer_q < TMR_W'(TIMEOUT))) begin
         timer_d = timer_q + TMR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

   assign timer_d_c = timer_d;

endmodule

// File: rtl/mem_req_batcher.sv
// Gathers memory requests into a 16-slot batch tagged with an 8-bit sort key and
// hands the whole batch to a downstream sorter.
//   clk, rst_n               : clock, async active-low reset
//   req_valid/req_ready      : request handshake, req_data is the 68-bit payload
//   flush                    : pulse to launch the current partial batch
//   batch_valid/batch_ready  : batch handshake
//   batch_count              : number of occupied slots (0..16)
//   batch_data               : slot i at [76*i+75 : 76*i], key in [75:68], payload in [67:0]
module mem_req_batcher
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned KEY_LSB = 20,
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned TMR_W   = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [PAYLOAD_W-1:0]           req_data,
   input  logic                           flush,
   output logic                           batch_valid,
   input  logic                           batch_ready,
   output logic [CNT_W-1:0]               batch_count,
   output logic [NUM_SLOTS*ENTRY_W-1:0]   batch_data
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [ENTRY_W-1:0] slot_q [NUM_SLOTS];
   logic [ENTRY_W-1:0] new_entry;
   logic [TMR_W-1:0]   timer_d;
   logic               accept, consume, launch;

   // Handshake outputs are pure decodes of the state register.
   assign req_ready   = (state_q == FILL);
   assign batch_valid = (state_q == HOLD);
   assign batch_count = count_q;

   assign accept  = req_valid & req_ready;
   assign consume = batch_valid & batch_ready;

   // Key MSB forced low so every real request sorts ahead of PAD_KEY.
   assign new_entry = {1'b0, req_data[KEY_LSB +: KEY_W-1], req_data};

   // Timer runs only while a non-empty batch is filling; frozen in HOLD.
   batch_timer #(
      .TIMEOUT (TIMEOUT),
      .TMR_W   (TMR_W)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (consume),
      .en_i      ((state_q == FILL) && (count_q != '0)),
      .timer_d_c (timer_d)
   );

   // Next state and occupancy; launch uses post-accept count and timer.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      launch  = 1'b0;
      case (state_q)
         FILL: begin
            if (accept) begin
               count_d = count_q + CNT_W'(1);
            end
            launch = (count_d == CNT_W'(NUM_SLOTS))
                  || ((TIMEOUT != 32'd0) && (timer_d == TMR_W'(TIMEOUT)) && (count_d != '0))
                  || (flush && (count_d != '0));
            if (launch) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (batch_ready) begin
               state_d = FILL;
               count_d = '0;
            end
         end
         default: state_d = FILL;
      endcase
   end

   // State, occupancy and slot storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILL;
         count_q <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_q[i] <= PAD_ENTRY;
         end
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         if (consume) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
               slot_q[i] <= PAD_ENTRY;
            end
         end else if (accept) begin
            slot_q[count_q[SLOT_IDX_W-1:0]] <= new_entry;
         end
      end
   end

   // Flatten slots onto the output bus.
   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_flat
      assign batch_data[g*ENTRY_W +: ENTRY_W] = slot_q[g];
   end

endmodule

// File: tb/tb_mem_req_batcher.sv
// Self-checking bench for mem_req_batcher: scoreboard of expected slot entries,
// one task per scenario, outputs sampled on the falling edge.
module tb_mem_req_batcher;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [67:0]   req_data = '0;
   logic          flush = 1'b0;
   logic          batch_valid;
   logic          batch_ready = 1'b0;
   logic [4:0]    batch_count;
   logic [1215:0] batch_data;

   int checks = 0;
   int failures = 0;
   logic [75:0] exp_q[$];

   localparam logic [75:0] PAD = {8'hFF, 68'h0};

   always #5 clk = ~clk;

   mem_req_batcher #(
      .KEY_LSB (20),
      .TIMEOUT (64),
      .TMR_W   (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_data    (req_data),
      .flush       (flush),
      .batch_valid (batch_valid),
      .batch_ready (batch_ready),
      .batch_count (batch_count),
      .batch_data  (batch_data)
   );

   function automatic logic [67:0] mk_data(input logic [6:0] key);
      logic [67:0] d;
      d = {4'($urandom()), $urandom(), $urandom()};
      d[26:20] = key;
      return d;
   endfunction

   // Present one request for one cycle (called at a falling edge); queue its
   // expected slot entry when the batcher is ready to take it.
   task automatic drive_req(input logic [67:0] d);
      req_valid = 1'b1;
      req_data  = d;
      if (req_ready === 1'b1) exp_q.push_back({1'b0, d[26:20], d});
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [1215:0] pad_vec;
      for (int i = 0; i < 16; i++) pad_vec[76*i +: 76] = PAD;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (batch_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", batch_valid); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
      checks++;
      if (batch_count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", batch_count); end
      checks++;
      if (batch_data !== pad_vec) begin failures++; $display("FAIL reset_slots got=%h", batch_data); end
   endtask

   task automatic test_full_batch();
      logic [75:0] e;
      int n_exp;
      int ready_bad;
      exp_q.delete();
      for (int i = 0; i < 16; i++) begin
         if (i == 15) begin
            checks++;
            if (batch_valid !== 1'b0) begin failures++; $display("FAIL full_early_valid got=%b exp=0", batch_valid); end
         end
         drive_req(mk_data(7'(15 - i)));
      end
      // Now one cycle after the 16th accept.
      checks++;
      if (batch_valid !== 1'b1) begin failures++; $display("FAIL full_valid got=%b exp=1", batch_valid); end
      n_exp = exp_q.size();
      checks++;
      if (batch_count !== 5'(n_exp) || n_exp != 16) begin
         failures++; $display("FAIL full_count got=%0d exp=16 queued=%0d", batch_count, n_exp);
      end
      for (int i = 0; i < 16; i++) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : PAD;
         checks++;
         if (batch_data[76*i +: 76] !== e) begin
            failures++; $display("FAIL full_slot%0d got=%h exp=%h", i, batch_data[76*i +: 76], e);
         end
         checks++;
         if (batch_data[76*i+68 +: 8] !== 8'(15 - i)) begin
            failures++; $display("FAIL full_key%0d got=%h exp=%h", i, batch_data[76*i+68 +: 8], 8'(15 - i));
         end
      end
      ready_bad = 0;
      repeat (3) begin
         if (req_ready !== 1'b0 || batch_valid !== 1'b1) ready_bad++;
         @(negedge clk);
      end
      checks++;
      if (ready_bad != 0) begin failures++; $display("FAIL full_hold_ready bad_cycles=%0d exp=0", ready_bad); end
      batch_ready = 1'b1;
      @(negedge clk);
      batch_ready = 1'b0;
      checks++;
      if (req_ready !== 1'b1 || batch_valid !== 1'b0) begin
         failures++; $display("FAIL full_release ready=%b valid=%b exp=1/0", req_ready, batch_valid);
      end
   endtask

   task automatic test_timeout();
      logic [75:0] e;
      int n;
      int n_exp;
      exp_q.delete();
      // n counts rising edges since the edge that took the first request.
      drive_req(mk_data(7'h33));
      drive_req(mk_data(7'h01));
      drive_req(mk_data(7'h33));
      n = 2;
      while (batch_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != 64) begin failures++; $display("FAIL timeout_latency got=%0d exp=64", n); end
      n_exp = exp_q.size();
      checks++;
      if (batch_count !== 5'd3 || n_exp != 3) begin
         failures++; $display("FAIL timeout_count got=%0d exp=3 queued=%0d", batch_count, n_exp);
      end
      for (int i = 0; i < 16; i++) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : PAD;
         checks++;
         if (batch_data[76*i +: 76] !== e) begin
            failures++; $display("FAIL timeout_slot%0d got=%h exp=%h", i, batch_data[76*i +: 76], e);
         end
      end
      batch_ready = 1'b1;
      @(negedge clk);
      batch_ready = 1'b0;
   endtask

   task automatic test_flush();
      logic [67:0] fifth;
      logic [75:0] e;
      int n_exp;
      exp_q.delete();
      for (int i = 0; i < 4; i++) drive_req(mk_data(7'(i * 9)));
      fifth = mk_data(7'h05);
      flush = 1'b1;
      drive_req(fifth);
      flush = 1'b0;
      checks++;
      if (batch_valid !== 1'b1) begin failures++; $display("FAIL flush_valid got=%b exp=1", batch_valid); end
      n_exp = exp_q.size();
      checks++;
      if (batch_count !== 5'd5 || n_exp != 5) begin
         failures++; $display("FAIL flush_count got=%0d exp=5 queued=%0d", batch_count, n_exp);
      end
      checks++;
      if (batch_data[4*76 +: 68] !== fifth) begin
         failures++; $display("FAIL flush_slot4_payload got=%h exp=%h", batch_data[4*76 +: 68], fifth);
      end
      for (int i = 0; i < 16; i++) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : PAD;
         checks++;
         if (batch_data[76*i +: 76] !== e) begin
            failures++; $display("FAIL flush_slot%0d got=%h exp=%h", i, batch_data[76*i +: 76], e);
         end
      end
      batch_ready = 1'b1;
      @(negedge clk);
      batch_ready = 1'b0;
   endtask

   task automatic test_flush_empty();
      int seen;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      seen = 0;
      repeat (100) begin
         if (batch_valid !== 1'b0) seen++;
         @(negedge clk);
      end
      checks++;
      if (seen != 0) begin failures++; $display("FAIL flush_empty_valid cycles=%0d exp=0", seen); end
      checks++;
      if (batch_count !== 5'd0 || req_ready !== 1'b1) begin
         failures++; $display("FAIL flush_empty_state count=%0d ready=%b exp=0/1", batch_count, req_ready);
      end
   endtask

   task automatic test_hold_backpressure();
      logic [1215:0] snap;
      logic [75:0] e;
      int unstable;
      int accepted;
      exp_q.delete();
      for (int i = 0; i < 5; i++) drive_req(mk_data(7'(40 - i)));
      flush = 1'b1;
      drive_req(mk_data(7'h7F));
      flush = 1'b0;
      checks++;
      if (batch_valid !== 1'b1 || batch_count !== 5'd6) begin
         failures++; $display("FAIL bp_launch valid=%b count=%0d exp=1/6", batch_valid, batch_count);
      end
      for (int i = 0; i < 16; i++) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : PAD;
         checks++;
         if (batch_data[76*i +: 76] !== e) begin
            failures++; $display("FAIL bp_slot%0d got=%h exp=%h", i, batch_data[76*i +: 76], e);
         end
      end
      snap = batch_data;
      unstable = 0;
      accepted = 0;
      repeat (20) begin
         req_valid = 1'b1;
         req_data  = mk_data(7'h11);
         if (req_ready !== 1'b0) accepted++;
         @(negedge clk);
         if (batch_data !== snap || batch_count !== 5'd6) unstable++;
      end
      req_valid = 1'b0;
      checks++;
      if (unstable != 0) begin failures++; $display("FAIL bp_stable bad_cycles=%0d exp=0", unstable); end
      checks++;
      if (accepted != 0) begin failures++; $display("FAIL bp_no_accept ready_cycles=%0d exp=0", accepted); end
      batch_ready = 1'b1;
      @(negedge clk);
      batch_ready = 1'b0;
      checks++;
      if (req_ready !== 1'b1 || batch_count !== 5'd0 || batch_valid !== 1'b0) begin
         failures++; $display("FAIL bp_release ready=%b count=%0d valid=%b exp=1/0/0", req_ready, batch_count, batch_valid);
      end
   endtask

   task automatic test_async_reset();
      int seen;
      exp_q.delete();
      for (int i = 0; i < 7; i++) drive_req(mk_data(7'(i)));
      checks++;
      if (batch_count !== 5'd7) begin failures++; $display("FAIL arst_pre_count got=%0d exp=7", batch_count); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (batch_count !== 5'd0 || req_ready !== 1'b1 || batch_valid !== 1'b0) begin
         failures++; $display("FAIL arst_immediate count=%0d ready=%b valid=%b exp=0/1/0", batch_count, req_ready, batch_valid);
      end
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (80) begin
         @(negedge clk);
         if (batch_valid !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0 || batch_count !== 5'd0 || req_ready !== 1'b1) begin
         failures++; $display("FAIL arst_after valid_cycles=%0d count=%0d ready=%b exp=0/0/1", seen, batch_count, req_ready);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_full_batch();
      test_timeout();
      test_flush();
      test_flush_empty();
      test_hold_backpressure();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
